pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, payload width (instruction + PC+4).
REQ-002 Parameter NOP_VALUE, default 0, DATA_W-bit payload driven on out_data when the stage holds no valid entry.
REQ-003 Parameter CNT_W, default 16, width of stall_cnt.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data is valid for downstream.
REQ-010 out_data  output  DATA_W  head payload, registered.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 hold  input  1  hazard stall; freezes stage.
REQ-013 flush  input  1  discard all entries (branch/exception).
REQ-014 stall_cnt  output  CNT_W  saturating count of hold cycles.

Function
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 Storage: main register (drives out_data) plus one skid register; states EMPTY, ONE, TWO.
REQ-017 in_ready = (state != TWO) & !hold & !flush & !reset.
REQ-018 out_valid = (state != EMPTY) & !hold.
REQ-019 EMPTY: in_fire -> ONE, main <= in_data.
REQ-020 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire only -> TWO, skid <= in_data; out_fire only -> EMPTY.
REQ-021 TWO: out_fire -> ONE, main <= skid; otherwise stay TWO, data unchanged.
REQ-022 Ordering: payloads leave in exactly the order accepted; no drop, no duplicate.
REQ-023 Latency: an accepted payload appears on out_data the cycle after in_fire when the stage was EMPTY, or when in the same cycle the stage was ONE and out_fire occurred.
REQ-024 hold=1: no transfer on either side; main, skid and state are unchanged.
REQ-025 flush=1: next state EMPTY, out_data <= NOP_VALUE, skid contents discarded; flush overrides hold, in_valid and out_ready.
REQ-026 Entering EMPTY by out_fire loads out_data <= NOP_VALUE.
REQ-027 stall_cnt increments by 1 on each cycle with hold=1 and flush=0, and saturates at 2^CNT_W-1 with no wrap.
REQ-028 Throughput: one payload per cycle sustained when out_ready=1 and hold=0.

Reset
REQ-029 reset=1 forces state EMPTY, out_data=NOP_VALUE, stall_cnt=0, and skid cleared to NOP_VALUE.
REQ-030 During reset, out_valid=0 and in_ready=0; reset overrides flush and hold.
REQ-031 Reset asserted mid-transfer discards all held payloads; the first cycle after reset deasserts gives in_ready=1.

Structure
REQ-032 Shared package pipe_pkg holds the state enum (EMPTY/ONE/TWO) and the default NOP constant.
REQ-033 Single module; no sub-module, because the skid slot is a plain register folded into the same always block.

Verification
REQ-034 Reset, then in_data=0x0000_0004_0000_0013 with in_valid=1 and out_ready=1 -> out_valid=1 next cycle with that data; in_ready stays 1 throughout.
REQ-035 Stream 0x01..0x05 back-to-back with out_ready=0 on cycles 2-3 -> state reaches TWO, in_ready=0, output order 01,02,03,04,05 with no loss.
REQ-036 Stage in ONE with 0xAA; hold=1 for 3 cycles -> out_valid=0, in_ready=0, data unchanged, stall_cnt=3; release -> 0xAA emitted once.
REQ-037 Stage in TWO (0x11, 0x22); pulse flush together with hold and in_valid -> next cycle EMPTY, out_data=NOP_VALUE, and neither 0x11 nor 0x22 is ever emitted.
REQ-038 CNT_W=4, hold=1 for 20 cycles -> stall_cnt saturates at 15.
REQ-039 Stage in TWO, assert reset for 1 cycle -> out_valid=0, out_data=NOP_VALUE, stall_cnt=0; next cycle in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and
// the default bubble payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int unsigned PIPE_DATA_W_DEFAULT = 64;
    localparam int unsigned PIPE_CNT_W_DEFAULT  = 16;
    localparam logic [63:0] PIPE_NOP_DEFAULT    = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage (main + skid) with hazard hold, flush and a
// saturating count of held cycles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         DATA_W    = PIPE_DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0]   NOP_VALUE = DATA_W'(PIPE_NOP_DEFAULT),
    parameter int unsigned         CNT_W     = PIPE_CNT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              hold,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_t      state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_fire;
    logic              out_fire;

    // Handshakes are gated by reset so nothing transfers while it is asserted.
    always_comb begin
        in_ready  = (state_q != TWO) && !hold && !flush && !reset;
        out_valid = (state_q != EMPTY) && !hold && !reset;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            if (hold && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // hold forces both fire signals low, so the FSM below is frozen by it.
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state_q <= TWO;
                        skid_q  <= in_data;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                        main_q  <= NOP_VALUE;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                        skid_q  <= NOP_VALUE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    main_q  <= NOP_VALUE;
                    skid_q  <= NOP_VALUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: reset, streaming with
// backpressure, hold, flush, stall counter saturation and mid-transfer reset.
module tb_pipe_stage_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        hold;
    logic        flush;
    logic [15:0] stall_cnt;

    logic        hold_b;
    logic        in_ready_b;
    logic        out_valid_b;
    logic [63:0] out_data_b;
    logic [3:0]  stall_cnt_b;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [63:0] log_q[$];

    always #5 clock = ~clock;

    pipe_stage_reg #(.DATA_W(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .hold(hold), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(1'b0), .in_data(64'h0), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(1'b0),
        .hold(hold_b), .flush(1'b0), .stall_cnt(stall_cnt_b)
    );

    // Payloads consumed downstream, captured mid-cycle while inputs are stable.
    always @(negedge clock) begin
        if (out_valid && out_ready) log_q.push_back(out_data);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        hold = 1'b0; flush = 1'b0; hold_b = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single transfer with immediate consumption.
        in_valid = 1'b1; in_data = 64'h0000_0004_0000_0013; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_data",  out_data,       64'h0000_0004_0000_0013);
        chk("single_in_ready",  64'(in_ready),  64'd1);
        tick();
        chk("single_drain_valid", 64'(out_valid), 64'd0);
        chk("single_drain_nop",   out_data,       64'd0);
        log_q.delete();

        // Stream 01..05, downstream stalls on cycles 2-3.
        in_valid = 1'b1; in_data = 64'h01; out_ready = 1'b1;
        tick();
        in_data = 64'h02; out_ready = 1'b0;
        tick();
        in_data = 64'h03; out_ready = 1'b0;
        #1;
        chk("stream_two_in_ready", 64'(in_ready),  64'd0);
        chk("stream_two_head",     out_data,       64'h01);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        in_data = 64'h04;
        tick();
        in_data = 64'h05;
        tick();
        in_valid = 1'b0;
        tick();
        chk("stream_empty_valid", 64'(out_valid), 64'd0);
        chk("stream_count", 64'(log_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stream_order_%0d", i),
                (i < log_q.size()) ? log_q[i] : 64'hDEAD, 64'(i + 1));
        end
        log_q.delete();

        // Hold freezes a single resident entry.
        in_valid = 1'b1; in_data = 64'hAA; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; hold = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_out_valid", 64'(out_valid), 64'd0);
            chk("hold_in_ready",  64'(in_ready),  64'd0);
            chk("hold_data",      out_data,       64'hAA);
            tick();
        end
        hold = 1'b0;
        #1;
        chk("hold_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("hold_release_valid", 64'(out_valid), 64'd1);
        chk("hold_release_data",  out_data,       64'hAA);
        tick();
        out_ready = 1'b0;
        tick(); tick();
        chk("hold_emit_count", 64'(log_q.size()), 64'd1);
        chk("hold_emit_data", (log_q.size() > 0) ? log_q[0] : 64'hDEAD, 64'hAA);
        log_q.delete();

        // Flush wins over hold and in_valid while two entries are resident.
        in_valid = 1'b1; in_data = 64'h11; out_ready = 1'b0;
        tick();
        in_data = 64'h22;
        tick();
        in_data = 64'h33; flush = 1'b1; hold = 1'b1; out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_data",  out_data,       64'd0);
        chk("flush_in_ready_after", 64'(in_ready), 64'd1);
        chk("flush_stall_cnt", 64'(stall_cnt), 64'd3);
        tick(); tick(); tick();
        chk("flush_no_emit", 64'(log_q.size()), 64'd0);

        // Reset while two entries are resident.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
        tick();
        in_data = 64'h66;
        tick();
        in_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready",  64'(in_ready),  64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_after_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_after_data",  out_data,       64'd0);
        chk("rst_mid_after_cnt",   64'(stall_cnt), 64'd0);
        chk("rst_mid_after_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_mid_no_emit", 64'(log_q.size()), 64'd0);

        // Narrow counter saturates at 15.
        out_ready = 1'b0;
        hold_b = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_cnt_14", 64'(stall_cnt_b), 64'd14);
        tick();
        chk("sat_cnt_15", 64'(stall_cnt_b), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt_20", 64'(stall_cnt_b), 64'd15);
        chk("sat_out_valid", 64'(out_valid_b), 64'd0);
        hold_b = 1'b0;
        tick();
        chk("sat_in_ready_b", 64'(in_ready_b), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
